// File: rtl/twos_acc_pkg.sv
// Shared types and default configuration for the two's-complement frame
// accumulator. Optional saturation is selected with TWOS_ACC_SAT_EN.
package twos_acc_pkg;

  // Frame FSM: collecting samples, or presenting the finished sum.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEF_DW        = 4;
  localparam int DEF_AW        = 8;
  localparam int DEF_FRAME_LEN = 10;

  // Saturation limits for the default accumulator width (+127 / -128).
  localparam logic signed [DEF_AW-1:0] DEF_SAT_MAX = {1'b0, {(DEF_AW-1){1'b1}}};
  localparam logic signed [DEF_AW-1:0] DEF_SAT_MIN = {1'b1, {(DEF_AW-1){1'b0}}};

endpackage

// File: rtl/twos_frame_accumulator_sat_add.sv
// Combinational sign-extend-and-add with signed overflow detection.
// With TWOS_ACC_SAT_EN defined the result clamps to the AW-bit signed range,
// otherwise it wraps modulo 2^AW.
module sat_add #(
  parameter int DW = 4,
  parameter int AW = 8
) (
  input  logic [AW-1:0] acc,
  input  logic [DW-1:0] data,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  logic [AW-1:0] data_sext;
  logic [AW-1:0] sum_raw;

  assign data_sext = {{(AW-DW){data[DW-1]}}, data};
  assign sum_raw   = acc + data_sext;

  // Overflow only when both operands share a sign and the result does not.
  assign ovf = (acc[AW-1] == data_sext[AW-1]) && (sum_raw[AW-1] != acc[AW-1]);

`ifdef TWOS_ACC_SAT_EN
  localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

  // Clamp toward the operands' common sign when the add overflows.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    sum = sum_raw;
    if (ovf) sum = acc[AW-1] ? SAT_MIN : SAT_MAX;
  end
`else
  assign sum = sum_raw;
`endif

endmodule

// File: rtl/twos_frame_accumulator.sv
// Frame accumulator: sums FRAME_LEN sign-extended samples, then holds the
// result until the downstream handshake. Saturation option: TWOS_ACC_SAT_EN.
module twos_frame_accumulator
  import twos_acc_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf
);

  localparam int            CW   = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  state_t        state, state_next;
  logic [AW-1:0] acc;
  logic [CW-1:0] count;
  logic          ovf_q;
  logic [AW-1:0] add_sum;
  logic          add_ovf;
  logic          accept;
  logic          release_frame;

  sat_add #(.DW(DW), .AW(AW)) u_sat_add (
    .acc  (acc),
    .data (in_data),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  assign accept        = in_valid && (state == ACCUM);
  assign release_frame = out_ready && (state == HOLD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  // Next-state: clear wins, otherwise the frame ends on its last accept.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && count == LAST) state_next = HOLD;
        HOLD:    if (release_frame)           state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  // Handshake outputs decoded from the state register alone.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b1;
    endcase
  end

  // Accumulator, sample counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      ovf_q <= 1'b0;
    end else if (clear || release_frame) begin
      acc   <= '0;
      count <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc   <= add_sum;
      count <= count + CW'(1);
      ovf_q <= ovf_q | add_ovf;
    end
  end

  assign out_sum = acc;
  assign out_ovf = ovf_q;

endmodule
